dp_sram_2port: RTL and testbench



---
 rtl/dp_sram_2port.sv | 128 ++++++++++++
 tb/tb_dp_sram_2port.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_sram_2port.sv
// True dual-port synchronous SRAM, one clock, read-first ports.
// Zero-fill sweep after reset; port A wins same-address write collisions.
module dp_sram_2port #(
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 8,
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_a,
  input  logic              we_a,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  output logic [DATA_W-1:0] dout_a,
  output logic              vld_a,
  input  logic              cs_b,
  input  logic              we_b,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_b,
  output logic [DATA_W-1:0] dout_b,
  output logic              vld_b,
  output logic              busy,
  output logic              coll
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [0:0] INIT  = 1'b0;
  localparam logic [0:0] READY = 1'b1;
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

  logic [0:0]        state;
  logic [ADDR_W:0]   cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              act;
  logic              wr_a;
  logic              wr_b;
  logic              rd_a;
  logic              rd_b;
  logic [DATA_W-1:0] d1_a;
  logic [DATA_W-1:0] d1_b;
  logic              v1_a;
  logic              v1_b;

  assign busy = rst | (state == INIT);
  assign act  = ~busy;
  assign wr_a = act & cs_a & we_a;
  assign wr_b = act & cs_b & we_b;
  assign rd_a = act & cs_a & re_a;
  assign rd_b = act & cs_b & re_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST) state <= READY;
    end
  end

  // B is written first so A's later assignment wins on a shared address
  always_ff @(posedge clk) begin
    if (!rst && state == INIT) begin
      mem[cnt[ADDR_W-1:0]] <= '0;
    end else begin
      if (wr_b) mem[addr_b] <= din_b;
      if (wr_a) mem[addr_a] <= din_a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d1_a <= '0;
      v1_a <= 1'b0;
    end else begin
      v1_a <= rd_a;
      if (act) begin
        if (!cs_a)     d1_a <= '0;
        else if (re_a) d1_a <= mem[addr_a];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d1_b <= '0;
      v1_b <= 1'b0;
    end else begin
      v1_b <= rd_b;
      if (act) begin
        if (!cs_b)     d1_b <= '0;
        else if (re_b) d1_b <= mem[addr_b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) coll <= 1'b0;
    else     coll <= wr_a & wr_b & (addr_a == addr_b);
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_a <= '0;
          dout_b <= '0;
          vld_a  <= 1'b0;
          vld_b  <= 1'b0;
        end else begin
          dout_a <= d1_a;
          dout_b <= d1_b;
          vld_a  <= v1_a;
          vld_b  <= v1_b;
        end
      end
    end else begin : g_noreg
      assign dout_a = d1_a;
      assign dout_b = d1_b;
      assign vld_a  = v1_a;
      assign vld_b  = v1_b;
    end
  endgenerate

endmodule

// File: tb/tb_dp_sram_2port.sv
// Bench for dp_sram_2port: vector table, reset corners and random traffic
// against an array-based reference, for both output latencies at once.
module tb_dp_sram_2port;

  localparam int DW    = 4;
  localparam int AW    = 8;
  localparam int DEPTH = 2 ** AW;

  logic          clk;
  logic          rst;
  logic          cs_a, we_a, re_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] din_a;
  logic          cs_b, we_b, re_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] din_b;

  logic [DW-1:0] o0_da, o0_db, o1_da, o1_db;
  logic          o0_va, o0_vb, o1_va, o1_vb;
  logic          o0_busy, o1_busy, o0_coll, o1_coll;

  dp_sram_2port #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0)) dut0 (
    .clk(clk), .rst(rst),
    .cs_a(cs_a), .we_a(we_a), .re_a(re_a), .addr_a(addr_a),
    .din_a(din_a), .dout_a(o0_da), .vld_a(o0_va),
    .cs_b(cs_b), .we_b(we_b), .re_b(re_b), .addr_b(addr_b),
    .din_b(din_b), .dout_b(o0_db), .vld_b(o0_vb),
    .busy(o0_busy), .coll(o0_coll)
  );

  dp_sram_2port #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(1)) dut1 (
    .clk(clk), .rst(rst),
    .cs_a(cs_a), .we_a(we_a), .re_a(re_a), .addr_a(addr_a),
    .din_a(din_a), .dout_a(o1_da), .vld_a(o1_va),
    .cs_b(cs_b), .we_b(we_b), .re_b(re_b), .addr_b(addr_b),
    .din_b(din_b), .dout_b(o1_db), .vld_b(o1_vb),
    .busy(o1_busy), .coll(o1_coll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: contents array, remaining sweep length, expected outputs
  logic [DW-1:0] mm [DEPTH];
  int            sweep_left;
  logic [DW-1:0] e1_da, e1_db, e2_da, e2_db;
  logic          e1_va, e1_vb, e2_va, e2_vb, e_coll;

  task automatic step();
    logic          act;
    logic [DW-1:0] rda, rdb;
    @(posedge clk);
    act = !rst && sweep_left == 0;
    if (rst) begin
      {e2_da, e2_db, e2_va, e2_vb} = '0;
      {e1_da, e1_db, e1_va, e1_vb, e_coll} = '0;
    end else begin
      {e2_da, e2_db, e2_va, e2_vb} = {e1_da, e1_db, e1_va, e1_vb};
      if (act) begin
        rda = mm[addr_a];
        rdb = mm[addr_b];
        if (!cs_a)     e1_da = '0;
        else if (re_a) e1_da = rda;
        if (!cs_b)     e1_db = '0;
        else if (re_b) e1_db = rdb;
        e1_va  = cs_a & re_a;
        e1_vb  = cs_b & re_b;
        e_coll = cs_a & we_a & cs_b & we_b & (addr_a == addr_b);
        if (cs_b && we_b) mm[addr_b] = din_b;
        if (cs_a && we_a) mm[addr_a] = din_a;
      end else begin
        e1_va  = 1'b0;
        e1_vb  = 1'b0;
        e_coll = 1'b0;
      end
    end
    if (rst) begin
      sweep_left = DEPTH;
      foreach (mm[i]) mm[i] = '0;
    end else if (sweep_left > 0) begin
      sweep_left--;
    end
    #1;
    chk("l1_dout_a", int'(o0_da), int'(e1_da));
    chk("l1_vld_a",  int'(o0_va), int'(e1_va));
    chk("l1_dout_b", int'(o0_db), int'(e1_db));
    chk("l1_vld_b",  int'(o0_vb), int'(e1_vb));
    chk("l2_dout_a", int'(o1_da), int'(e2_da));
    chk("l2_vld_a",  int'(o1_va), int'(e2_va));
    chk("l2_dout_b", int'(o1_db), int'(e2_db));
    chk("l2_vld_b",  int'(o1_vb), int'(e2_vb));
    chk("coll0", int'(o0_coll), int'(e_coll));
    chk("coll1", int'(o1_coll), int'(e_coll));
    chk("busy0", int'(o0_busy), int'(rst || sweep_left > 0));
    chk("busy1", int'(o1_busy), int'(rst || sweep_left > 0));
  endtask

  task automatic idle_in();
    {cs_a, we_a, re_a, cs_b, we_b, re_b} = '0;
    addr_a = '0; addr_b = '0;
    din_a = '0;  din_b = '0;
  endtask

  // release reset, then count cycles until busy drops
  task automatic sweep_len(input string name);
    int n;
    rst = 1'b0;
    n = 0;
    while (o0_busy && n < 400) begin
      step();
      n++;
    end
    chk(name, n, DEPTH);
  endtask

  typedef struct {
    logic          ca, wa, ra;
    logic [AW-1:0] aa;
    logic [DW-1:0] da;
    logic          cb, wb, rb;
    logic [AW-1:0] ab;
    logic [DW-1:0] db;
    logic [DW-1:0] xda;
    logic          xva;
    logic [DW-1:0] xdb;
    logic          xvb;
    logic          xc;
  } vec_t;

  vec_t vt [11];

  initial begin
    vt[0]  = '{1'b1,1'b1,1'b0,8'h10,4'hA, 1'b1,1'b0,1'b1,8'h00,4'h0,
               4'h0,1'b0,4'h0,1'b1,1'b0};
    vt[1]  = '{1'b1,1'b0,1'b1,8'h7F,4'h0, 1'b1,1'b0,1'b1,8'h10,4'h0,
               4'h0,1'b1,4'hA,1'b1,1'b0};
    vt[2]  = '{1'b1,1'b1,1'b0,8'h20,4'h3, 1'b1,1'b0,1'b1,8'hFF,4'h0,
               4'h0,1'b0,4'h0,1'b1,1'b0};
    vt[3]  = '{1'b1,1'b1,1'b0,8'h20,4'h5, 1'b1,1'b0,1'b1,8'h20,4'h0,
               4'h0,1'b0,4'h3,1'b1,1'b0};
    vt[4]  = '{1'b0,1'b0,1'b1,8'h00,4'h0, 1'b1,1'b0,1'b1,8'h20,4'h0,
               4'h0,1'b0,4'h5,1'b1,1'b0};
    vt[5]  = '{1'b1,1'b1,1'b0,8'h30,4'h1, 1'b1,1'b1,1'b0,8'h30,4'h2,
               4'h0,1'b0,4'h5,1'b0,1'b1};
    vt[6]  = '{1'b1,1'b0,1'b1,8'h30,4'h0, 1'b1,1'b1,1'b0,8'h31,4'h7,
               4'h1,1'b1,4'h5,1'b0,1'b0};
    vt[7]  = '{1'b1,1'b1,1'b1,8'h10,4'hC, 1'b1,1'b0,1'b1,8'h31,4'h0,
               4'hA,1'b1,4'h7,1'b1,1'b0};
    vt[8]  = '{1'b1,1'b0,1'b1,8'h10,4'h0, 1'b0,1'b0,1'b1,8'h00,4'h0,
               4'hC,1'b1,4'h0,1'b0,1'b0};
    vt[9]  = '{1'b1,1'b0,1'b0,8'h00,4'h0, 1'b1,1'b0,1'b1,8'h30,4'h0,
               4'hC,1'b0,4'h1,1'b1,1'b0};
    vt[10] = '{1'b0,1'b0,1'b0,8'h00,4'h0, 1'b0,1'b0,1'b0,8'h00,4'h0,
               4'h0,1'b0,4'h0,1'b0,1'b0};

    idle_in();
    sweep_left = DEPTH;
    rst = 1'b1;
    step();
    step();
    chk("rst_dout_a", int'(o0_da), 0);
    chk("rst_busy", int'(o0_busy), 1);
    sweep_len("sweep_len");

    // directed vector table
    foreach (vt[i]) begin
      {cs_a, we_a, re_a} = {vt[i].ca, vt[i].wa, vt[i].ra};
      addr_a = vt[i].aa; din_a = vt[i].da;
      {cs_b, we_b, re_b} = {vt[i].cb, vt[i].wb, vt[i].rb};
      addr_b = vt[i].ab; din_b = vt[i].db;
      step();
      chk($sformatf("vec%0d_dout_a", i), int'(o0_da), int'(vt[i].xda));
      chk($sformatf("vec%0d_vld_a", i),  int'(o0_va), int'(vt[i].xva));
      chk($sformatf("vec%0d_dout_b", i), int'(o0_db), int'(vt[i].xdb));
      chk($sformatf("vec%0d_vld_b", i),  int'(o0_vb), int'(vt[i].xvb));
      chk($sformatf("vec%0d_coll", i),   int'(o0_coll), int'(vt[i].xc));
    end
    step();

    // reset at sweep count 100 restarts the full sweep
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (100) step();
    chk("mid_sweep_busy", int'(o0_busy), 1);
    rst = 1'b1;
    step();
    sweep_len("restart_sweep_len");

    // reset with reads in flight on both latencies
    cs_a = 1'b1; we_a = 1'b1; addr_a = 8'h50; din_a = 4'hF;
    step();
    idle_in();
    cs_a = 1'b1; re_a = 1'b1; addr_a = 8'h50;
    cs_b = 1'b1; re_b = 1'b1; addr_b = 8'h50;
    step();
    chk("inflight_l1", int'(o0_da), 15);
    idle_in();
    rst = 1'b1;
    step();
    chk("rst_vld_l2", int'(o1_va), 0);
    chk("rst_dout_l2", int'(o1_da), 0);
    sweep_len("rezero_sweep_len");
    cs_a = 1'b1; re_a = 1'b1; addr_a = 8'h50;
    step();
    chk("rezero_data", int'(o0_da), 0);
    chk("rezero_vld", int'(o0_va), 1);

    // random traffic on a small address window to force collisions
    for (int i = 0; i < 1500; i++) begin
      cs_a = ($urandom_range(0, 3) != 0);
      we_a = 1'($urandom);
      re_a = 1'($urandom);
      addr_a = 8'($urandom_range(0, 7));
      din_a = 4'($urandom);
      cs_b = ($urandom_range(0, 3) != 0);
      we_b = 1'($urandom);
      re_b = 1'($urandom);
      addr_b = 8'($urandom_range(0, 7));
      din_b = 4'($urandom);
      step();
    end
    idle_in();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
